// File: rtl/stopwatch_core.sv
// Stopwatch core: debounced start/lap/clear buttons drive a BCD SS.hh counter
// with a lap register and a sticky overflow state at 99.99.
module stopwatch_core #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [3:0] l3,
    output logic [3:0] l2,
    output logic [3:0] l1,
    output logic [3:0] l0,
    output logic       run,
    output logic       start_press,
    output logic       lap_press,
    output logic       flash,
    output logic [1:0] dbg_state
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_OVF   = 2'd3
    } state_t;

    state_t state, state_nx;

    // ---------------- button conditioning ----------------
    logic [2:0]    btn_raw;
    logic [2:0]    sync1, sync2, acc, press_r;
    logic [DW-1:0] db_cnt [3];
    logic          clear_press;

    assign btn_raw = {btn_clear, btn_lap, btn_start};

    // The press pulse is produced in the same edge that accepts a new high
    // level, so it comes straight out of a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            acc     <= '0;
            press_r <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press_r[i] <= 1'b0;
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    acc[i]     <= sync2[i];
                    press_r[i] <= sync2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign start_press = press_r[0];
    assign lap_press   = press_r[1];
    assign clear_press = press_r[2];

    // ---------------- control FSM ----------------
    logic [PW-1:0] presc;
    logic          tick, at_max, do_clear;

    assign tick     = (state == S_RUN) && (presc == PW'(DIV - 1));
    assign at_max   = (d3 == 4'd9) && (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);
    assign do_clear = clear_press && (state != S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Clear beats start when both arrive together outside RUN.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (clear_press)      state_nx = S_IDLE;
                else if (start_press) state_nx = S_RUN;
            end
            S_RUN: begin
                if (tick && at_max)   state_nx = S_OVF;
                else if (start_press) state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (clear_press)      state_nx = S_IDLE;
                else if (start_press) state_nx = S_RUN;
            end
            S_OVF: begin
                if (clear_press)      state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            flash <= 1'b0;
        end else begin
            run   <= (state_nx == S_RUN);
            flash <= (state_nx == S_OVF);
        end
    end

    assign dbg_state = state;

    // ---------------- BCD datapath ----------------
    logic [3:0] nd3, nd2, nd1, nd0;

    always_comb begin
        nd3 = d3;
        nd2 = d2;
        nd1 = d1;
        nd0 = d0;
        if (d0 >= 4'd9) begin
            nd0 = 4'd0;
            if (d1 >= 4'd9) begin
                nd1 = 4'd0;
                if (d2 >= 4'd9) begin
                    nd2 = 4'd0;
                    nd3 = (d3 >= 4'd9) ? 4'd0 : d3 + 4'd1;
                end else begin
                    nd2 = d2 + 4'd1;
                end
            end else begin
                nd1 = d1 + 4'd1;
            end
        end else begin
            nd0 = d0 + 4'd1;
        end
    end

    // Lap copies the current (pre-increment) digits, so a lap that lands on a
    // tick or on a stop sees the value shown during that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc          <= '0;
            {d3, d2, d1, d0} <= '0;
            {l3, l2, l1, l0} <= '0;
        end else if (do_clear) begin
            presc          <= '0;
            {d3, d2, d1, d0} <= '0;
            {l3, l2, l1, l0} <= '0;
        end else begin
            if (state == S_RUN) begin
                presc <= tick ? '0 : presc + 1'b1;
                if (tick && !at_max) {d3, d2, d1, d0} <= {nd3, nd2, nd1, nd0};
                if (lap_press)       {l3, l2, l1, l0} <= {d3, d2, d1, d0};
            end
        end
    end

endmodule
